// File: rtl/peripheral_uart_rx_if.sv
// J1 I/O bus bundle shared by the UART receive peripheral and its host.
// The CPU side drives the strobes and write data, and the peripheral returns registered read data.
interface peripheral_uart_rx_if;
   logic [15:0] d_in;
   logic        cs;
   logic [3:0]  addr;
   logic        rd;
   logic        wr;
   logic [15:0] d_out;

   modport master (output d_in, output cs, output addr, output rd, output wr, input d_out);
   modport slave  (input d_in, input cs, input addr, input rd, input wr, output d_out);
endinterface

// File: rtl/peripheral_uart_rx.sv
// 8N1 UART receiver with a small receive FIFO.
// STATUS, DATA and CTRL registers are reachable over the J1 I/O bus.
module peripheral_uart_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   peripheral_uart_rx_if.slave   io_bus,
   input  logic                  i_uart_rx,
   output logic                  o_rx_irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(CLKS_PER_BIT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [TW-1:0] T_ONE   = TW'(1);
   localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   P_ONE   = (AW + 1)'(1);

   logic          r_rx_meta;
   logic          r_rxs;
   logic [1:0]    r_sync_cnt;
   logic          r_armed;
   logic [1:0]    r_state;
   logic [TW-1:0] r_tcnt;
   logic [2:0]    r_bcnt;
   logic [7:0]    r_shreg;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic          r_overrun;
   logic          r_frame_err;
   logic          r_data_rd_d;
   logic [15:0]   r_d_out;
   logic          r_rx_irq;

   logic          w_tick_half;
   logic          w_tick_full;
   logic          w_stop_done;
   logic          w_push_req;
   logic          w_frame_bad;
   logic          w_full;
   logic          w_empty;
   logic          w_data_rd;
   logic          w_pop;
   logic          w_ctrl_wr;
   logic          w_flush;
   logic          w_push;
   logic          w_overrun_set;
   logic [15:0]   w_rd_data;
   logic          w_unused;

   assign w_tick_half   = (r_tcnt == HALF_M1);
   assign w_tick_full   = (r_tcnt == FULL_M1);
   assign w_stop_done   = (r_state == S_STOP) && w_tick_full;
   assign w_push_req    = w_stop_done && r_rxs;
   assign w_frame_bad   = w_stop_done && !r_rxs;

   assign w_empty       = (r_wptr == r_rptr);
   assign w_full        = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_data_rd     = io_bus.cs && io_bus.rd && (io_bus.addr == 4'd2);
   assign w_pop         = w_data_rd && !r_data_rd_d && !w_empty;
   assign w_ctrl_wr     = io_bus.cs && io_bus.wr && !io_bus.rd && (io_bus.addr == 4'd4);
   assign w_flush       = w_ctrl_wr && io_bus.d_in[2];
   // A full FIFO still accepts the byte when a pop or flush frees room in the same cycle
   assign w_push        = w_push_req && (!w_full || w_pop || w_flush);
   assign w_overrun_set = w_push_req && !w_push;
   assign w_unused      = ^io_bus.d_in[15:3];

   assign io_bus.d_out  = r_d_out;
   assign o_rx_irq      = r_rx_irq;

   // Synchronizer; reception is armed only once the settled line has been seen idle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_meta  <= 1'b1;
         r_rxs      <= 1'b1;
         r_sync_cnt <= 2'd0;
         r_armed    <= 1'b0;
      end else begin
         r_rx_meta <= i_uart_rx;
         r_rxs     <= r_rx_meta;
         if (r_sync_cnt != 2'd2) r_sync_cnt <= r_sync_cnt + 2'd1;
         if ((r_sync_cnt == 2'd2) && r_rxs) r_armed <= 1'b1;
      end
   end

   // Receive FSM: mid-bit sampling timed from the start edge
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_tcnt  <= '0;
         r_bcnt  <= 3'd0;
         r_shreg <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tcnt <= '0;
               r_bcnt <= 3'd0;
               if (r_armed && !r_rxs) r_state <= S_START;
            end
            S_START: begin
               if (w_tick_half) begin
                  r_tcnt  <= '0;
                  r_state <= r_rxs ? S_IDLE : S_DATA;
               end else begin
                  r_tcnt <= r_tcnt + T_ONE;
               end
            end
            S_DATA: begin
               if (w_tick_full) begin
                  r_tcnt  <= '0;
                  r_shreg <= {r_rxs, r_shreg[7:1]};
                  r_bcnt  <= r_bcnt + 3'd1;
                  if (r_bcnt == 3'd7) r_state <= S_STOP;
               end else begin
                  r_tcnt <= r_tcnt + T_ONE;
               end
            end
            S_STOP: begin
               if (w_tick_full) begin
                  r_tcnt  <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_tcnt <= r_tcnt + T_ONE;
               end
            end
            default: begin
               r_tcnt  <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // FIFO storage; a flush moves the read pointer onto the pre-push write pointer
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
      end else begin
         if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= r_shreg;
            r_wptr                <= r_wptr + P_ONE;
         end
         if (w_flush)    r_rptr <= r_wptr;
         else if (w_pop) r_rptr <= r_rptr + P_ONE;
      end
   end

   // Read mux decode
   always_comb begin
      w_rd_data = 16'h0000;
      if (io_bus.cs && io_bus.rd) begin
         case (io_bus.addr)
            4'd0: w_rd_data = {12'h000, w_full, r_overrun, r_frame_err, !w_empty};
            4'd2: begin
               if (!w_empty) w_rd_data = {8'h00, r_mem[r_rptr[AW-1:0]]};
               else          w_rd_data = 16'h0000;
            end
            default: w_rd_data = 16'h0000;
         endcase
      end else begin
         w_rd_data = 16'h0000;
      end
   end

   // Bus-facing registers; a new error event wins over a clear in the same cycle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
         r_data_rd_d <= 1'b0;
         r_d_out     <= 16'h0000;
         r_rx_irq    <= 1'b0;
      end else begin
         if (w_overrun_set)                     r_overrun <= 1'b1;
         else if (w_ctrl_wr && io_bus.d_in[0])  r_overrun <= 1'b0;
         if (w_frame_bad)                       r_frame_err <= 1'b1;
         else if (w_ctrl_wr && io_bus.d_in[1])  r_frame_err <= 1'b0;
         r_data_rd_d <= w_data_rd;
         r_d_out     <= w_rd_data;
         r_rx_irq    <= !w_empty;
      end
   end
endmodule

// File: tb/tb_peripheral_uart_rx.sv
// Scoreboard bench for peripheral_uart_rx: the expected FIFO contents and flags are modelled in the bench.
// Every DATA read is compared against the head of that model.
module tb_peripheral_uart_rx;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   logic uart_rx;
   logic rx_irq;

   peripheral_uart_rx_if bus();

   peripheral_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .io_bus    (bus),
      .i_uart_rx (uart_rx),
      .o_rx_irq  (rx_irq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];
   logic m_overrun = 1'b0;
   logic m_frame   = 1'b0;

   function automatic logic [15:0] m_status();
      return {12'h000, (exp_q.size() == DEPTH), m_overrun, m_frame, (exp_q.size() != 0)};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 4'd0; bus.d_in = 16'h0000;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
      bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
      cyc(1);
      d = bus.d_out;
      bus_idle();
      cyc(1);
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [15:0] v);
      bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = v;
      cyc(1);
      bus_idle();
      cyc(1);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         cyc(CPB);
      end
      uart_rx = stop;
      cyc(CPB);
      uart_rx = 1'b1;
      cyc(CPB);
      if (!stop)                      m_frame = 1'b1;
      else if (exp_q.size() < DEPTH)  exp_q.push_back(b);
      else                            m_overrun = 1'b1;
   endtask

   task automatic read_data_exp(output logic [15:0] got, output logic [15:0] exp);
      bus_read(4'd2, got);
      if (exp_q.size() != 0) exp = {8'h00, exp_q.pop_front()};
      else                   exp = 16'h0000;
   endtask

   task automatic test_reset();
      logic [15:0] got;
      rst = 1'b1; uart_rx = 1'b1; bus_idle();
      cyc(5);
      rst = 1'b0;
      cyc(3);
      checks++; if (bus.d_out !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", bus.d_out); end
      checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", rx_irq); end
      bus_read(4'd0, got);
      checks++; if (got !== 16'h0000) begin errors++; $display("FAIL reset_status: got %h expected 0000", got); end
   endtask

   task automatic test_single();
      logic [15:0] got, exp;
      send_frame(8'hA5, 1'b1);
      checks++; if (rx_irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b expected 1", rx_irq); end
      bus_read(4'd0, got);
      checks++; if (got !== m_status()) begin errors++; $display("FAIL single_status: got %h expected %h", got, m_status()); end
      read_data_exp(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL single_data: got %h expected %h", got, exp); end
      bus_read(4'd0, got);
      checks++; if (got !== 16'h0000) begin errors++; $display("FAIL single_status_after: got %h expected 0000", got); end
      checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL single_irq_after: got %b expected 0", rx_irq); end
   endtask

   task automatic test_overrun();
      logic [15:0] got, exp;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      bus_read(4'd0, got);
      checks++; if (got !== 16'h000D) begin errors++; $display("FAIL ovr_status: got %h expected 000d", got); end
      for (int i = 0; i < 5; i++) begin
         read_data_exp(got, exp);
         checks++; if (got !== exp) begin errors++; $display("FAIL ovr_data%0d: got %h expected %h", i, got, exp); end
      end
      bus_write(4'd4, 16'h0001);
      m_overrun = 1'b0;
      bus_read(4'd0, got);
      checks++; if (got !== m_status()) begin errors++; $display("FAIL ovr_clear: got %h expected %h", got, m_status()); end
   endtask

   task automatic test_frame_err();
      logic [15:0] got;
      send_frame(8'h3C, 1'b0);
      bus_read(4'd0, got);
      checks++; if (got !== 16'h0002) begin errors++; $display("FAIL ferr_status: got %h expected 0002", got); end
      bus_write(4'd4, 16'h0002);
      m_frame = 1'b0;
      bus_read(4'd0, got);
      checks++; if (got !== m_status()) begin errors++; $display("FAIL ferr_clear: got %h expected %h", got, m_status()); end
   endtask

   task automatic test_glitch();
      logic [15:0] got, exp;
      uart_rx = 1'b0;
      cyc(3);
      uart_rx = 1'b1;
      cyc(2 * CPB);
      bus_read(4'd0, got);
      checks++; if (got !== 16'h0000) begin errors++; $display("FAIL glitch_status: got %h expected 0000", got); end
      checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b expected 0", rx_irq); end
      send_frame(8'h5A, 1'b1);
      read_data_exp(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL glitch_next_data: got %h expected %h", got, exp); end
   endtask

   task automatic test_hold_rd();
      logic [15:0] got, exp;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      bus_read(4'd6, got);
      checks++; if (got !== 16'h0000) begin errors++; $display("FAIL other_addr: got %h expected 0000", got); end
      bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = 4'd2;
      cyc(1);
      got = bus.d_out;
      exp = {8'h00, exp_q.pop_front()};
      cyc(4);
      bus_idle();
      cyc(1);
      checks++; if (got !== exp) begin errors++; $display("FAIL hold_first: got %h expected %h", got, exp); end
      bus_read(4'd0, got);
      checks++; if (got !== m_status()) begin errors++; $display("FAIL hold_status: got %h expected %h", got, m_status()); end
      read_data_exp(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL hold_second: got %h expected %h", got, exp); end
   endtask

   task automatic test_rd_wr_both();
      logic [15:0] got;
      send_frame(8'h99, 1'b0);
      bus.cs = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = 4'd4; bus.d_in = 16'h0002;
      cyc(1);
      got = bus.d_out;
      bus_idle();
      cyc(1);
      checks++; if (got !== 16'h0000) begin errors++; $display("FAIL rdwr_dout: got %h expected 0000", got); end
      bus_read(4'd0, got);
      checks++; if (got !== m_status()) begin errors++; $display("FAIL rdwr_flag_kept: got %h expected %h", got, m_status()); end
      bus_write(4'd4, 16'h0002);
      m_frame = 1'b0;
   endtask

   task automatic test_flush();
      logic [15:0] got, exp;
      send_frame(8'h33, 1'b1);
      send_frame(8'h44, 1'b1);
      bus_write(4'd4, 16'h0004);
      exp_q.delete();
      bus_read(4'd0, got);
      checks++; if (got !== m_status()) begin errors++; $display("FAIL flush_status: got %h expected %h", got, m_status()); end
      checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL flush_irq: got %b expected 0", rx_irq); end
      read_data_exp(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL flush_data: got %h expected %h", got, exp); end
   endtask

   task automatic test_rst_mid();
      logic [15:0] got, exp;
      uart_rx = 1'b0;
      cyc(CPB);
      cyc(4 * CPB);
      cyc(CPB / 2);
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(2 * CPB);
      uart_rx = 1'b1;
      cyc(3 * CPB);
      exp_q.delete(); m_overrun = 1'b0; m_frame = 1'b0;
      bus_read(4'd0, got);
      checks++; if (got !== 16'h0000) begin errors++; $display("FAIL rst_mid_status: got %h expected 0000", got); end
      send_frame(8'h7E, 1'b1);
      bus_read(4'd0, got);
      checks++; if (got !== 16'h0001) begin errors++; $display("FAIL rst_mid_avail: got %h expected 0001", got); end
      read_data_exp(got, exp);
      checks++; if (got !== exp) begin errors++; $display("FAIL rst_mid_data: got %h expected %h", got, exp); end
      bus_read(4'd0, got);
      checks++; if (got !== 16'h0000) begin errors++; $display("FAIL rst_mid_final: got %h expected 0000", got); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_single();
      test_overrun();
      test_frame_err();
      test_glitch();
      test_hold_rd();
      test_rd_wr_both();
      test_flush();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
